// File: rtl/uart_rx_fifo.sv
// Receive byte buffer behind the UART receiver: toggle-flag byte detect, show-ahead FIFO, sticky overrun, irq.
// Define UART_RX_FIFO_THRESH_EN to raise irq on a fill threshold instead of on not-empty.
module uart_rx_fifo #(
  parameter int ADDR_W     = 4,
  parameter int IRQ_THRESH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_flag,
  input  logic              rd_en,
  input  logic              clr_overrun,
  output logic [7:0]        rd_data,
  output logic              rx_valid,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              overrun,
  output logic              irq
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [7:0]        mem [DEPTH];
  logic              flag_d;
  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] rptr;
  logic              byte_stb;
  logic              push;
  logic              pop;
  logic              ovf;
  logic              irq_cond;

  assign byte_stb = rx_flag ^ flag_d;
  assign rx_valid = (count != '0);
  assign full     = count[ADDR_W];
  assign pop      = rd_en & rx_valid;
  // A full FIFO still accepts a byte when the head is popped on the same edge.
  assign push     = byte_stb & (~full | pop);
  assign ovf      = byte_stb & full & ~pop;
  assign rd_data  = rx_valid ? mem[rptr] : 8'h00;

`ifdef UART_RX_FIFO_THRESH_EN
  localparam logic [ADDR_W:0] THRESH_C = IRQ_THRESH[ADDR_W:0];
  if (IRQ_THRESH < 1 || IRQ_THRESH > DEPTH) begin : g_bad_thresh
    $error("uart_rx_fifo: IRQ_THRESH out of range");
  end
  assign irq_cond = (count >= THRESH_C) | overrun;
`else
  assign irq_cond = (count != '0) | overrun;
`endif

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= rx_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_d  <= 1'b0;
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
      overrun <= 1'b0;
      irq     <= 1'b0;
    end else begin
      flag_d <= rx_flag;
      irq    <= irq_cond;
      if (push) begin
        wptr <= wptr + 1'b1;
      end
      if (pop) begin
        rptr <= rptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (ovf) begin
        overrun <= 1'b1;
      end else if (clr_overrun) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: push/pop ordering, full/overrun handling, empty reads, irq and async reset.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_flag;
  logic       rd_en;
  logic       clr_overrun;
  logic [7:0] rd_data;
  logic       rx_valid;
  logic       full;
  logic [4:0] count;
  logic       overrun;
  logic       irq;

  int n_checks = 0;
  int n_pass   = 0;

  uart_rx_fifo #(.ADDR_W(4), .IRQ_THRESH(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_data     (rx_data),
    .rx_flag     (rx_flag),
    .rd_en       (rd_en),
    .clr_overrun (clr_overrun),
    .rd_data     (rd_data),
    .rx_valid    (rx_valid),
    .full        (full),
    .count       (count),
    .overrun     (overrun),
    .irq         (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    rx_data = d;
    rx_flag = ~rx_flag;
    tick();
  endtask

  task automatic pop();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    rx_flag = 1'b0;
    rd_en   = 1'b0;
    clr_overrun = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    rx_data = 8'h00;
    do_reset();
    check("rst_valid", rx_valid, 0);
    check("rst_full", full, 0);
    check("rst_count", count, 0);
    check("rst_irq", irq, 0);
    check("rst_rd_data", rd_data, 8'h00);
    check("rst_overrun", overrun, 0);

    // 1: single byte in and out
    push(8'hA5);
    check("t1_valid", rx_valid, 1);
    check("t1_data", rd_data, 8'hA5);
    check("t1_count", count, 1);
    pop();
    check("t1_pop_valid", rx_valid, 0);
    check("t1_pop_count", count, 0);

    // 2: fill to 16
    for (int i = 0; i < 16; i++) push(8'(i));
    check("t2_full", full, 1);
    check("t2_count", count, 16);

    // 3: overflow drops byte
    push(8'hEE);
    check("t3_overrun", overrun, 1);
    check("t3_count", count, 16);
    check("t3_head", rd_data, 8'h00);
    clr_overrun = 1'b1;
    tick();
    clr_overrun = 1'b0;
    check("t3_clr", overrun, 0);

    // 4: push with pop while full
    rd_en = 1'b1;
    push(8'h55);
    rd_en = 1'b0;
    check("t4_count", count, 16);
    check("t4_overrun", overrun, 0);
    for (int i = 1; i < 17; i++) begin
      check($sformatf("t4_order%0d", i), rd_data, (i == 16) ? 8'h55 : 8'(i));
      pop();
    end
    check("t4_empty", rx_valid, 0);
    check("t4_zero", rd_data, 8'h00);

    // 5: pops on empty are ignored
    rd_en = 1'b1;
    repeat (3) tick();
    rd_en = 1'b0;
    check("t5_count", count, 0);
    check("t5_valid", rx_valid, 0);
    push(8'h11);
    check("t5_data", rd_data, 8'h11);
    check("t5_count1", count, 1);
    pop();
    // push with rd_en while empty: only the push happens
    rd_en = 1'b1;
    push(8'h22);
    rd_en = 1'b0;
    check("t5_pushpop_count", count, 1);
    check("t5_pushpop_data", rd_data, 8'h22);

    // 6: irq behaviour then async reset
    do_reset();
`ifdef UART_RX_FIFO_THRESH_EN
    for (int i = 0; i < 7; i++) push(8'h30 + 8'(i));
    tick();
    check("t6_irq7", irq, 0);
    push(8'h37);
    check("t6_irq8_lag", irq, 0);
    tick();
    check("t6_irq8", irq, 1);
`else
    push(8'h30);
    check("t6_irq1_lag", irq, 0);
    tick();
    check("t6_irq1", irq, 1);
    push(8'h31);
`endif
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_count", count, 0);
    check("t6_rst_irq", irq, 0);
    check("t6_rst_valid", rx_valid, 0);
    rx_flag = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check("t6_post_count", count, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
